// File: rtl/stage_d_pkg.sv
// Shared encodings for the yari decode stage: MIPS-I opcode, function and REGIMM fields,
// the load predicate, the operand bypass helper and the registered decode bundle.
package stage_d_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_CP0     = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWR     = 6'h26;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RI_BLTZAL  = 5'h10;
    localparam logic [4:0] RI_BGEZAL  = 5'h11;
    localparam logic [4:0] CP0_MF     = 5'h00;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [5:0]  opcode;
        logic [5:0]  fn;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [31:0] target;
        logic [5:0]  wbr;
        logic        has_delay_slot;
        logic [31:0] op1_val;
        logic [31:0] op2_val;
        logic [31:0] rt_val;
        logic [31:0] simm;
        logic        restart;
        logic [31:0] restart_pc;
    } d_out_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    endfunction

    // X result beats M result beats the register file; r0 is never bypassed.
    function automatic logic [31:0] bypass(input logic [5:0] idx, input logic [31:0] rf_val,
                                           input logic xv, input logic [5:0] xw,
                                           input logic [31:0] xr, input logic mv,
                                           input logic [5:0] mw, input logic [31:0] mr);
        if (idx == 6'd0)             return 32'd0;
        else if (xv && (xw == idx))  return xr;
        else if (mv && (mw == idx))  return mr;
        else                         return rf_val;
    endfunction

endpackage

// File: rtl/stage_d_regfile.sv
// 32x32 general-purpose register file: two asynchronous read ports, one synchronous
// write port; entry 0 always reads as zero and is never written.
module regfile_2r1w (
    input  logic        clock,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clock) begin
        if (we_i && (waddr_i != 5'd0)) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : mem_q[raddr_b_i];

endmodule

// File: rtl/stage_d.sv
// yari decode stage: registers the fetched instruction, decodes fields, immediates and
// targets, reads bypassed operands and flags load-use hazards for restart.
module stage_d
    import stage_d_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_npc,
    input  logic        x_valid,
    input  logic [5:0]  x_wbr,
    input  logic [31:0] x_res,
    input  logic        m_valid,
    input  logic [5:0]  m_wbr,
    input  logic [31:0] m_res,
    input  logic [31:0] m_pc,
    input  logic        flush_D,
    output logic        d_valid,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_npc,
    output logic [5:0]  d_opcode,
    output logic [5:0]  d_fn,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_sa,
    output logic [5:0]  d_rs,
    output logic [5:0]  d_rt,
    output logic [31:0] d_target,
    output logic [5:0]  d_wbr,
    output logic        d_has_delay_slot,
    output logic [31:0] d_op1_val,
    output logic [31:0] d_op2_val,
    output logic [31:0] d_rt_val,
    output logic [31:0] d_simm,
    output logic        d_restart,
    output logic [31:0] d_restart_pc,
    output logic        d_flush_X
);

    d_out_t      d_q, d_d;
    logic [31:0] rf_rs, rf_rt, rs_val, rt_val, simm;
    logic [5:0]  op, fn, rs6, rt6;
    logic [15:0] imm;
    logic        rf_we, hazard;
    logic        unused_m_pc;

    assign unused_m_pc = ^m_pc;

    assign op   = i_instr[31:26];
    assign fn   = i_instr[5:0];
    assign rs6  = {1'b0, i_instr[25:21]};
    assign rt6  = {1'b0, i_instr[20:16]};
    assign imm  = i_instr[15:0];
    assign simm = {{16{imm[15]}}, imm};

    // m_wbr[5] marks non-GPR destinations (e.g. coprocessor), which never hit the file.
    assign rf_we = m_valid && !m_wbr[5] && (m_wbr[4:0] != 5'd0);

    regfile_2r1w u_rf (
        .clock     (clock),
        .we_i      (rf_we),
        .waddr_i   (m_wbr[4:0]),
        .wdata_i   (m_res),
        .raddr_a_i (i_instr[25:21]),
        .rdata_a_o (rf_rs),
        .raddr_b_i (i_instr[20:16]),
        .rdata_b_o (rf_rt)
    );

    assign rs_val = bypass(rs6, rf_rs, x_valid, x_wbr, x_res, m_valid, m_wbr, m_res);
    assign rt_val = bypass(rt6, rf_rt, x_valid, x_wbr, x_res, m_valid, m_wbr, m_res);

    // The load sitting in D will only have its data after M, so its consumer must re-run.
    assign hazard = i_valid && d_q.valid && !flush_D && is_load(d_q.opcode) &&
                    (d_q.wbr != 6'd0) && ((d_q.wbr == rs6) || (d_q.wbr == rt6));

    always_comb begin
        d_d            = '0;
        d_d.valid      = i_valid;
        d_d.instr      = i_instr;
        d_d.pc         = i_pc;
        d_d.npc        = i_npc;
        d_d.opcode     = op;
        d_d.fn         = fn;
        d_d.rd         = i_instr[15:11];
        d_d.sa         = i_instr[10:6];
        d_d.rs         = rs6;
        d_d.rt         = rt6;
        d_d.op1_val    = rs_val;
        d_d.rt_val     = rt_val;
        d_d.simm       = simm;
        d_d.restart    = hazard;
        d_d.restart_pc = i_pc;

        if ((op == OP_J) || (op == OP_JAL))
            d_d.target = {i_npc[31:28], i_instr[25:0], 2'b00};
        else
            d_d.target = i_npc + {simm[29:0], 2'b00};

        unique case (op)
            OP_SPECIAL, OP_BEQ, OP_BNE: d_d.op2_val = rt_val;
            OP_ANDI, OP_ORI, OP_XORI:   d_d.op2_val = {16'h0, imm};
            OP_LUI:                     d_d.op2_val = {imm, 16'h0};
            default:                    d_d.op2_val = simm;
        endcase

        unique case (op)
            OP_SPECIAL: d_d.wbr = (fn == FN_JR) ? 6'd0 : {1'b0, i_instr[15:11]};
            OP_JAL:     d_d.wbr = 6'd31;
            OP_REGIMM:  d_d.wbr = ((i_instr[20:16] == RI_BLTZAL) ||
                                   (i_instr[20:16] == RI_BGEZAL)) ? 6'd31 : 6'd0;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                        d_d.wbr = rt6;
            OP_CP0:     d_d.wbr = (i_instr[25:21] == CP0_MF) ? rt6 : 6'd0;
            default:    d_d.wbr = is_load(op) ? rt6 : 6'd0;
        endcase

        d_d.has_delay_slot = (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                                         OP_REGIMM}) ||
                             ((op == OP_SPECIAL) && ((fn == FN_JR) || (fn == FN_JALR)));
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) d_q <= '0;
        else      d_q <= d_d;
    end

    assign d_valid          = d_q.valid;
    assign d_instr          = d_q.instr;
    assign d_pc             = d_q.pc;
    assign d_npc            = d_q.npc;
    assign d_opcode         = d_q.opcode;
    assign d_fn             = d_q.fn;
    assign d_rd             = d_q.rd;
    assign d_sa             = d_q.sa;
    assign d_rs             = d_q.rs;
    assign d_rt             = d_q.rt;
    assign d_target         = d_q.target;
    assign d_wbr            = d_q.wbr;
    assign d_has_delay_slot = d_q.has_delay_slot;
    assign d_op1_val        = d_q.op1_val;
    assign d_op2_val        = d_q.op2_val;
    assign d_rt_val         = d_q.rt_val;
    assign d_simm           = d_q.simm;
    assign d_restart        = d_q.restart;
    assign d_restart_pc     = d_q.restart_pc;
    assign d_flush_X        = 1'b0;

endmodule

// File: tb/tb_stage_d.sv
// Directed bench for stage_d: stimulus pushes hand-computed expectations into a queue,
// a monitor pops and compares each time the stage presents d_valid.
module tb_stage_d;

    logic        clock = 1'b0;
    logic        rst;
    logic        i_valid, x_valid, m_valid, flush_D;
    logic [31:0] i_instr, i_pc, i_npc, x_res, m_res, m_pc;
    logic [5:0]  x_wbr, m_wbr;
    logic        d_valid, d_has_delay_slot, d_restart, d_flush_X;
    logic [31:0] d_instr, d_pc, d_npc, d_target, d_op1_val, d_op2_val, d_rt_val, d_simm;
    logic [31:0] d_restart_pc;
    logic [5:0]  d_opcode, d_fn, d_rs, d_rt, d_wbr;
    logic [4:0]  d_rd, d_sa;

    stage_d dut (
        .clock(clock), .rst(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
        .i_npc(i_npc), .x_valid(x_valid), .x_wbr(x_wbr), .x_res(x_res),
        .m_valid(m_valid), .m_wbr(m_wbr), .m_res(m_res), .m_pc(m_pc), .flush_D(flush_D),
        .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_npc(d_npc),
        .d_opcode(d_opcode), .d_fn(d_fn), .d_rd(d_rd), .d_sa(d_sa), .d_rs(d_rs),
        .d_rt(d_rt), .d_target(d_target), .d_wbr(d_wbr),
        .d_has_delay_slot(d_has_delay_slot), .d_op1_val(d_op1_val),
        .d_op2_val(d_op2_val), .d_rt_val(d_rt_val), .d_simm(d_simm),
        .d_restart(d_restart), .d_restart_pc(d_restart_pc), .d_flush_X(d_flush_X)
    );

    always #5 clock = ~clock;

    localparam int M_WBR = 1, M_OP1 = 2, M_OP2 = 4, M_SIMM = 8;
    localparam int M_TGT = 16, M_DS = 32, M_RST = 64, M_RPC = 128;

    typedef struct {
        logic [31:0] instr;
        int          mask;
        logic [5:0]  wbr;
        logic [31:0] op1, op2, simm, target;
        logic        dslot, restart;
        logic [31:0] rpc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input int mask,
                                input logic [5:0] wbr, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [31:0] simm,
                                input logic [31:0] target, input logic dslot,
                                input logic restart, input logic [31:0] rpc);
        exp_t e;
        e.instr = instr; e.mask = mask; e.wbr = wbr; e.op1 = op1; e.op2 = op2;
        e.simm = simm; e.target = target; e.dslot = dslot; e.restart = restart; e.rpc = rpc;
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] npc, input exp_t e);
        i_valid = 1'b1; i_instr = ins; i_pc = pc; i_npc = npc;
        q.push_back(e);
    endtask

    task automatic side(input logic xv, input logic [5:0] xw, input logic [31:0] xr,
                        input logic mv, input logic [5:0] mw, input logic [31:0] mr,
                        input logic fl);
        x_valid = xv; x_wbr = xw; x_res = xr;
        m_valid = mv; m_wbr = mw; m_res = mr; flush_D = fl;
    endtask

    // Monitor: sample one step after each rising edge.
    always @(posedge clock) begin
        #1;
        if (rst && d_valid) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_valid: got d_instr 0x%08h expected no output", d_instr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("d_instr", d_instr, e.instr);
                if ((e.mask & M_WBR) != 0)  chk("d_wbr", {26'd0, d_wbr}, {26'd0, e.wbr});
                if ((e.mask & M_OP1) != 0)  chk("d_op1_val", d_op1_val, e.op1);
                if ((e.mask & M_OP2) != 0)  chk("d_op2_val", d_op2_val, e.op2);
                if ((e.mask & M_SIMM) != 0) chk("d_simm", d_simm, e.simm);
                if ((e.mask & M_TGT) != 0)  chk("d_target", d_target, e.target);
                if ((e.mask & M_DS) != 0)   chk("d_has_delay_slot", {31'd0, d_has_delay_slot},
                                                {31'd0, e.dslot});
                if ((e.mask & M_RST) != 0)  chk("d_restart", {31'd0, d_restart},
                                                {31'd0, e.restart});
                if ((e.mask & M_RPC) != 0)  chk("d_restart_pc", d_restart_pc, e.rpc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_npc = '0; m_pc = '0;
        side(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
        #12;
        chk("reset_d_valid", {31'd0, d_valid}, 32'd0);
        chk("reset_d_restart", {31'd0, d_restart}, 32'd0);
        chk("reset_d_wbr", {26'd0, d_wbr}, 32'd0);
        chk("reset_d_target", d_target, 32'd0);
        @(negedge clock); rst = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_d_valid", {31'd0, d_valid}, 32'd0);

        issue(32'h24020005, 32'hBFC00000, 32'hBFC00004,
              mk(32'h24020005, M_WBR|M_OP1|M_OP2|M_SIMM|M_TGT|M_DS|M_RST,
                 6'd2, 32'd0, 32'd5, 32'd5, 32'hBFC00018, 1'b0, 1'b0, 32'd0));
        @(negedge clock);
        side(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 32'h1234, 1'b0);
        issue(32'h00632021, 32'hBFC00004, 32'hBFC00008,
              mk(32'h00632021, M_WBR|M_OP1|M_OP2|M_RST, 6'd4, 32'h1234, 32'h1234,
                 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
        issue(32'h00632021, 32'hBFC00008, 32'hBFC0000C,
              mk(32'h00632021, M_OP1|M_OP2, 6'd0, 32'h1234, 32'h1234, 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b0, 6'd0, 32'd0, 1'b1, 6'h23, 32'hDEAD, 1'b0);
        issue(32'h00632021, 32'hBFC0000C, 32'hBFC00010,
              mk(32'h00632021, M_OP1, 6'd0, 32'h1234, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
        issue(32'h00632021, 32'hBFC00010, 32'hBFC00014,
              mk(32'h00632021, M_OP1|M_OP2, 6'd0, 32'h1234, 32'h1234, 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b1, 6'd5, 32'hAAAA, 1'b1, 6'd5, 32'hBBBB, 1'b0);
        issue(32'h00A03021, 32'h0, 32'h4,
              mk(32'h00A03021, M_WBR|M_OP1, 6'd6, 32'hAAAA, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b0, 6'd5, 32'hAAAA, 1'b1, 6'd5, 32'hBBBB, 1'b0);
        issue(32'h00A03021, 32'h4, 32'h8,
              mk(32'h00A03021, M_OP1, 6'd0, 32'hBBBB, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b1, 6'd0, 32'h5555, 1'b1, 6'd0, 32'hFFFF, 1'b0);
        issue(32'h00002021, 32'h8, 32'hC,
              mk(32'h00002021, M_OP1|M_OP2, 6'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0));
        @(negedge clock);
        side(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
        issue(32'h3C01ABCD, 32'hC, 32'h10,
              mk(32'h3C01ABCD, M_WBR|M_OP1|M_OP2|M_SIMM, 6'd1, 32'd0, 32'hABCD0000,
                 32'hFFFFABCD, 0, 0, 0, 0));
        @(negedge clock);
        issue(32'h34228001, 32'h10, 32'h14,
              mk(32'h34228001, M_WBR|M_OP2|M_SIMM, 6'd2, 0, 32'h00008001, 32'hFFFF8001,
                 0, 0, 0, 0));
        @(negedge clock);
        issue(32'h8D280000, 32'h1FC, 32'h200,
              mk(32'h8D280000, M_WBR|M_OP2|M_RST, 6'd8, 0, 32'd0, 0, 0, 0, 1'b0, 0));
        @(negedge clock);
        issue(32'h01005021, 32'h200, 32'h204,
              mk(32'h01005021, M_WBR|M_RST|M_RPC, 6'd10, 0, 0, 0, 0, 0, 1'b1, 32'h200));
        @(negedge clock);
        issue(32'h8D280000, 32'h1FC, 32'h200,
              mk(32'h8D280000, M_RST, 6'd0, 0, 0, 0, 0, 0, 1'b0, 0));
        @(negedge clock);
        flush_D = 1'b1;
        issue(32'h01005021, 32'h200, 32'h204,
              mk(32'h01005021, M_RST, 6'd0, 0, 0, 0, 0, 0, 1'b0, 0));
        @(negedge clock);
        flush_D = 1'b0;
        issue(32'h1000FFFF, 32'h100, 32'h104,
              mk(32'h1000FFFF, M_WBR|M_TGT|M_DS|M_RST, 6'd0, 0, 0, 0, 32'h100, 1'b1,
                 1'b0, 0));
        @(negedge clock);
        issue(32'h0C100000, 32'hBFC00004, 32'hBFC00008,
              mk(32'h0C100000, M_WBR|M_TGT|M_DS, 6'd31, 0, 0, 0, 32'hB0400000, 1'b1, 0, 0));
        @(negedge clock);
        issue(32'h03E00008, 32'h20, 32'h24,
              mk(32'h03E00008, M_WBR|M_DS, 6'd0, 0, 0, 0, 0, 1'b1, 0, 0));
        @(negedge clock);
        issue(32'h04110003, 32'hFFC, 32'h1000,
              mk(32'h04110003, M_WBR|M_TGT|M_DS|M_SIMM, 6'd31, 0, 0, 32'd3, 32'h100C,
                 1'b1, 0, 0));
        @(negedge clock);
        issue(32'hAD280004, 32'h30, 32'h34,
              mk(32'hAD280004, M_WBR|M_OP2|M_DS|M_TGT|M_RST, 6'd0, 0, 32'd4, 0, 32'h44,
                 1'b0, 1'b0, 0));
        @(negedge clock);
        issue(32'h8D280000, 32'h2FC, 32'h300,
              mk(32'h8D280000, M_WBR, 6'd8, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        issue(32'hAD280004, 32'h300, 32'h304,
              mk(32'hAD280004, M_RST|M_RPC, 6'd0, 0, 0, 0, 0, 0, 1'b1, 32'h300));
        @(negedge clock);
        issue(32'h8D200000, 32'h304, 32'h308,
              mk(32'h8D200000, M_WBR|M_RST, 6'd0, 0, 0, 0, 0, 0, 1'b0, 0));
        @(negedge clock);
        issue(32'h00002021, 32'h308, 32'h30C,
              mk(32'h00002021, M_RST, 6'd0, 0, 0, 0, 0, 0, 1'b0, 0));
        @(negedge clock);
        i_valid = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end

        // Asynchronous reset while an instruction is held in D.
        @(negedge clock);
        issue(32'h24020005, 32'h40, 32'h44,
              mk(32'h24020005, M_WBR, 6'd2, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #3;
        i_valid = 1'b0; rst = 1'b0;
        #1;
        chk("async_rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("async_rst_d_wbr", {26'd0, d_wbr}, 32'd0);
        chk("async_rst_d_op2_val", d_op2_val, 32'd0);
        @(negedge clock); rst = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_d_valid", {31'd0, d_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
